// File: rtl/stage3_mem_arbiter.sv
// Shares the single memory bus port between instruction fetch and the data stage.
// D-side has priority; a starvation counter forces a fetch grant after STARVE_LIMIT D grants.
module stage3_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                iren,
  input  logic [ADDR_W-1:0]   iaddr,
  output logic                i_busy,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                dren,
  input  logic                dwen,
  input  logic [ADDR_W-1:0]   daddr,
  input  logic [DATA_W-1:0]   dwdata,
  input  logic [DATA_W/8-1:0] dbyte_en,
  output logic                d_busy,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                ren,
  output logic                wen,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] byte_en,
  input  logic                busy,
  input  logic [DATA_W-1:0]   rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;

  logic d_req, i_done, d_done, arb;
  logic can_i, can_d, force_i, gnt_i, gnt_d;

  // The side completing this cycle is excluded so the other side goes back-to-back.
  always_comb begin
    d_req   = dren | dwen;
    i_done  = (state == GNT_I) && !busy;
    d_done  = (state == GNT_D) && !busy;
    arb     = (state == IDLE) || i_done || d_done;
    can_i   = iren  && (state != GNT_I);
    can_d   = d_req && (state != GNT_D);
    force_i = can_i && (starve_cnt == CNT_W'(STARVE_LIMIT));
    gnt_d   = arb && can_d && !force_i;
    gnt_i   = arb && can_i && !gnt_d;
  end

  assign i_busy  = iren  && !i_done;
  assign d_busy  = d_req && !d_done;
  assign i_rdata = i_done ? rdata : '0;
  assign d_rdata = d_done ? rdata : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      ren        <= 1'b0;
      wen        <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      byte_en    <= '0;
      starve_cnt <= '0;
    end else if (gnt_d) begin
      // Write wins when both D strobes are raised.
      state   <= GNT_D;
      ren     <= !dwen;
      wen     <= dwen;
      addr    <= daddr;
      wdata   <= dwen ? dwdata : '0;
      byte_en <= dwen ? dbyte_en : '1;
      if (!iren)
        starve_cnt <= '0;
      else if (starve_cnt != CNT_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end else if (gnt_i) begin
      state      <= GNT_I;
      ren        <= 1'b1;
      wen        <= 1'b0;
      addr       <= iaddr;
      wdata      <= '0;
      byte_en    <= '1;
      starve_cnt <= '0;
    end else if (i_done || d_done) begin
      state <= IDLE;
      ren   <= 1'b0;
      wen   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stage3_mem_arbiter.sv
// Scoreboard bench for stage3_mem_arbiter: directed scenarios push expected bus
// transactions and completions; a negedge monitor pops and compares them.
module tb_stage3_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              CLK = 1'b0;
  logic              RST;
  logic              iren, dren, dwen;
  logic [ADDR_W-1:0] iaddr, daddr, addr;
  logic [DATA_W-1:0] dwdata, i_rdata, d_rdata, wdata;
  logic [DATA_W-1:0] rdata = '0;
  logic [3:0]        dbyte_en, byte_en;
  logic              i_busy, d_busy, ren, wen;
  logic              busy = 1'b0;

  stage3_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .iren(iren), .iaddr(iaddr), .i_busy(i_busy), .i_rdata(i_rdata),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dwdata(dwdata), .dbyte_en(dbyte_en),
    .d_busy(d_busy), .d_rdata(d_rdata),
    .ren(ren), .wen(wen), .addr(addr), .wdata(wdata), .byte_en(byte_en),
    .busy(busy), .rdata(rdata)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] i_q[$];
  logic [31:0] d_q[$];
  int          rsp_lat[$];
  logic [31:0] rsp_dat[$];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    bus_t e;
    e.wen = w; e.addr = a; e.wdata = d; e.be = b;
    bus_q.push_back(e);
  endtask

  task automatic rsp(input int lat, input logic [31:0] d);
    rsp_lat.push_back(lat);
    rsp_dat.push_back(d);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  // Bus slave: each new strobe takes the next latency/data pair from the response queue.
  int rem    = 0;
  bit in_txn = 1'b0;
  always @(posedge CLK) begin
    #1;
    if (ren || wen) begin
      if (!in_txn) begin
        if (rsp_lat.size() > 0) begin
          rem   = rsp_lat.pop_front();
          rdata = rsp_dat.pop_front();
        end else begin
          rem   = 0;
          rdata = '0;
        end
      end
      busy = (rem > 0);
      if (rem > 0) rem--;
      in_txn = busy;
    end else begin
      busy   = 1'b0;
      in_txn = 1'b0;
    end
  end

  // Monitor: bus transaction starts/holds and per-side completions.
  bus_t cur;
  bit   cont = 1'b0;
  task automatic chk_bus(input string tag);
    chk({tag, "_wen"}, wen, cur.wen);
    chk({tag, "_ren"}, ren, !cur.wen);
    chk({tag, "_addr"}, addr, cur.addr);
    chk({tag, "_byte_en"}, byte_en, cur.be);
    if (cur.wen) chk({tag, "_wdata"}, wdata, cur.wdata);
  endtask

  always @(negedge CLK) begin
    if (dren && dwen) begin
      bad++;
      $display("FAIL protocol: dren and dwen both high");
    end
    if (ren || wen) begin
      if (!cont) begin
        if (bus_q.size() == 0) begin
          total++; bad++;
          $display("FAIL bus_unexpected: addr=%0h expected no transaction", addr);
        end else begin
          cur = bus_q.pop_front();
          chk_bus("bus_start");
        end
      end else begin
        chk_bus("bus_hold");
      end
    end
    if (iren && !i_busy) begin
      if (i_q.size() == 0) begin
        total++; bad++;
        $display("FAIL i_unexpected: i_rdata=%0h expected no completion", i_rdata);
      end else chk("i_rdata", i_rdata, i_q.pop_front());
    end
    if ((dren || dwen) && !d_busy) begin
      if (d_q.size() == 0) begin
        total++; bad++;
        $display("FAIL d_unexpected: d_rdata=%0h expected no completion", d_rdata);
      end else chk("d_rdata", d_rdata, d_q.pop_front());
    end
    cont = (ren || wen) && busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; iren = 0; iaddr = 0; dren = 0; dwen = 0; daddr = 0; dwdata = 0; dbyte_en = 0;
    repeat (3) step();
    smp();
    chk("rst_ren", ren, 0); chk("rst_wen", wen, 0); chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0); chk("rst_byte_en", byte_en, 0);
    chk("rst_i_busy", i_busy, 0); chk("rst_d_busy", d_busy, 0);
    step(); RST = 1'b0;

    // Lone fetch, bus busy two cycles.
    exp_bus(0, 32'h200, 0, 4'hF); rsp(2, 32'hDEADBEEF); i_q.push_back(32'hDEADBEEF);
    step(); iren = 1; iaddr = 32'h200;
    smp(); chk("t1_c0_ren", ren, 0); chk("t1_c0_i_busy", i_busy, 1);
    step(); smp(); chk("t1_c1_ren", ren, 1); chk("t1_c1_addr", addr, 32'h200); chk("t1_c1_d_busy", d_busy, 0);
    step(); smp(); chk("t1_c2_i_busy", i_busy, 1);
    step(); smp(); chk("t1_c3_i_busy", i_busy, 0); chk("t1_c3_d_busy", d_busy, 0);
    step(); iren = 0; smp(); chk("t1_c4_ren", ren, 0);

    // Simultaneous requests: D first, I back-to-back.
    exp_bus(0, 32'h8000, 0, 4'hF); exp_bus(0, 32'h300, 0, 4'hF);
    rsp(1, 32'h1111); rsp(1, 32'h2222); d_q.push_back(32'h1111); i_q.push_back(32'h2222);
    step(); iren = 1; iaddr = 32'h300; dren = 1; daddr = 32'h8000;
    step(); smp(); chk("t2_c1_ren", ren, 1); chk("t2_c1_addr", addr, 32'h8000);
    step(); smp(); chk("t2_c2_d_busy", d_busy, 0); chk("t2_c2_i_busy", i_busy, 1);
    step(); dren = 0; smp(); chk("t2_c3_ren", ren, 1); chk("t2_c3_addr", addr, 32'h300);
    step(); smp(); chk("t2_c4_i_busy", i_busy, 0);
    step(); iren = 0; smp(); chk("t2_c5_ren", ren, 0);

    // Starvation: four D grants with fetch pending, then the fetch is forced.
    for (int k = 0; k < 4; k++) begin
      exp_bus(0, 32'h9000, 0, 4'hF); rsp(0, 32'hA0 + k); d_q.push_back(32'hA0 + k);
    end
    exp_bus(0, 32'h400, 0, 4'hF); rsp(0, 32'h4444); i_q.push_back(32'h4444);
    exp_bus(0, 32'h9000, 0, 4'hF); rsp(0, 32'h5555); d_q.push_back(32'h5555);
    iaddr = 32'h400; daddr = 32'h9000;
    for (int k = 0; k < 4; k++) begin
      step(); iren = 1; dren = 1;
      step(); iren = 0;
      smp(); chk("t3_d_done", d_busy, 0);
    end
    step(); iren = 1; dren = 1;
    smp(); chk("t3_cnt_limit", dut.starve_cnt, 4);
    step(); smp();
    chk("t3_i_ren", ren, 1); chk("t3_i_addr", addr, 32'h400);
    chk("t3_cnt_cleared", dut.starve_cnt, 0); chk("t3_i_busy", i_busy, 0);
    step(); iren = 0; smp(); chk("t3_d_addr", addr, 32'h9000); chk("t3_d_busy", d_busy, 0);
    step(); dren = 0;

    // Write with partial byte enables; changed write data after grant is ignored.
    exp_bus(1, 32'h8004, 32'h1234, 4'b0011); rsp(2, 0); d_q.push_back(0);
    step(); dwen = 1; daddr = 32'h8004; dwdata = 32'h1234; dbyte_en = 4'b0011;
    step(); smp(); chk("t4_wen", wen, 1); chk("t4_byte_en", byte_en, 4'b0011);
    chk("t4_wdata", wdata, 32'h1234); chk("t4_c1_d_busy", d_busy, 1);
    step(); dwdata = 32'hFFFF; dbyte_en = 4'hF; smp(); chk("t4_wdata_hold", wdata, 32'h1234);
    step(); smp(); chk("t4_c3_d_busy", d_busy, 0); chk("t4_c3_wen", wen, 1);
    step(); dwen = 0; smp(); chk("t4_c4_wen", wen, 0);

    // Abandoned fetch runs to completion before D is granted.
    exp_bus(0, 32'h500, 0, 4'hF); exp_bus(0, 32'h8008, 0, 4'hF);
    rsp(3, 32'h5050); rsp(0, 32'h6060); d_q.push_back(32'h6060);
    step(); iren = 1; iaddr = 32'h500;
    step(); smp(); chk("t5_c1_addr", addr, 32'h500); chk("t5_c1_i_busy", i_busy, 1);
    step(); iren = 0; dren = 1; daddr = 32'h8008;
    smp(); chk("t5_c2_addr", addr, 32'h500); chk("t5_c2_d_busy", d_busy, 1);
    step(); smp(); chk("t5_c3_addr", addr, 32'h500);
    step(); smp(); chk("t5_c4_addr", addr, 32'h500); chk("t5_c4_d_busy", d_busy, 1);
    step(); smp(); chk("t5_c5_addr", addr, 32'h8008); chk("t5_c5_d_busy", d_busy, 0);
    step(); dren = 0;

    // Reset during a D transaction, then a fresh fetch.
    exp_bus(0, 32'h800C, 0, 4'hF); exp_bus(0, 32'h600, 0, 4'hF);
    rsp(5, 32'h7777); rsp(1, 32'h6666); i_q.push_back(32'h6666);
    step(); dren = 1; daddr = 32'h800C;
    step(); smp(); chk("t6_c1_ren", ren, 1);
    step(); RST = 1; smp(); chk("t6_c2_d_busy", d_busy, 1);
    step(); RST = 0; dren = 0; iren = 1; iaddr = 32'h600;
    smp(); chk("t6_c3_ren", ren, 0); chk("t6_c3_wen", wen, 0);
    chk("t6_c3_state", dut.state, 0); chk("t6_c3_cnt", dut.starve_cnt, 0);
    step(); smp(); chk("t6_c4_ren", ren, 1); chk("t6_c4_addr", addr, 32'h600);
    step(); smp(); chk("t6_c5_i_busy", i_busy, 0);
    step(); iren = 0;

    repeat (3) step();
    chk("end_bus_q_empty", bus_q.size(), 0);
    chk("end_i_q_empty", i_q.size(), 0);
    chk("end_d_q_empty", d_q.size(), 0);
    chk("end_rsp_q_empty", rsp_lat.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
